// File: rtl/complex_div_arb_pkg.sv
// Shared types for the complex_div requester arbiter and its ID FIFO.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Contents: default sizing, requester index type, operand/result bundles, FP status flags.
package complex_div_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int MAX_OUT_DEF = 4;
  localparam int IDX_W       = $clog2(NUM_REQ_DEF);

  typedef logic [IDX_W-1:0] req_idx_t;

  // {b2,a2,b1,a1}, FP64 each; element 0 is a1
  typedef logic [3:0][63:0] operand_t;

  // {imag,real}, FP64 each; element 0 is real
  typedef logic [1:0][63:0] result_t;

  // Same layout as fpnew_pkg::status_t
  typedef struct packed {
    logic nv;  // invalid
    logic dz;  // divide by zero
    logic of;  // overflow
    logic uf;  // underflow
    logic nx;  // inexact
  } status_t;

endpackage

// File: rtl/complex_div_id_fifo.sv
// In-order FIFO of requester indices for operations in flight in the divider.
// Latency: a push is visible at data_o on the next cycle; count updates on the edge.
// Backpressure: push while full and pop while empty are ignored; clear empties in one cycle.
// Ports: clk_i, rst_i (sync, active-high), clear_i, push_i/data_i, pop_i/data_o,
//        full_o, empty_o, count_o (0..DEPTH).
module complex_div_id_fifo
  import complex_div_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(req_idx_t)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];

  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when counted as valid
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/complex_div_arbiter.sv
// Shares one untagged complex_div among NUM_REQ requesters: round-robin issue, in-order return routing.
// Latency: 0 cycles added on issue and on return (combinational steering, registered bookkeeping).
// Backpressure: issue stalls on device not ready, full ID FIFO or flush; return stalls on owner's rsp_ready_i.
// Ports: clk_i/rst_i; flush_i; req_* requester issue side; rsp_* shared return bus with per-requester
//        valid/ready; dev_* complex_div handshake; outstanding_o/busy_o in-flight count; error_o sticky orphan result.
module complex_div_arbiter
  import complex_div_arb_pkg::*;
#(
  parameter  int NUM_REQ         = 4,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int IDX_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ-1:0][3:0][63:0]  req_operands_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  input  logic [NUM_REQ-1:0]             rsp_ready_i,
  output result_t                        rsp_result_o,
  output status_t                        rsp_status_o,
  output operand_t                       dev_operands_o,
  output logic                           dev_valid_o,
  input  logic                           dev_ready_i,
  input  result_t                        dev_result_i,
  input  status_t                        dev_status_i,
  input  logic                           dev_out_valid_i,
  output logic                           dev_out_ready_o,
  output logic                           dev_flush_o,
  output logic [CNT_W-1:0]               outstanding_o,
  output logic                           busy_o,
  output logic                           error_o
);

  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_error;

  logic             w_req_any;
  logic [IDX_W-1:0] w_grant_idx;
  logic [IDX_W-1:0] w_grant_next;
  logic             w_can_issue;
  logic             w_issue;
  logic             w_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [IDX_W-1:0] w_head;

  // ---------------- issue side ----------------

  // First valid requester at or after r_rr_ptr, wrapping past NUM_REQ-1
  always_comb begin
    w_req_any   = 1'b0;
    w_grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_req_any && req_valid_i[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
        w_req_any   = 1'b1;
        w_grant_idx = IDX_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  // A full FIFO blocks issue even when a pop happens this cycle, keeping
  // rsp_ready_i out of the dev_valid_o cone
  assign w_can_issue = dev_ready_i & ~w_fifo_full & ~flush_i & ~rst_i;
  assign w_issue     = w_req_any & w_can_issue;

  assign dev_valid_o    = w_issue;
  assign dev_operands_o = w_issue ? req_operands_i[w_grant_idx] : '0;

  always_comb begin
    req_ready_o = '0;
    if (w_issue) req_ready_o[w_grant_idx] = 1'b1;
  end

  // NUM_REQ need not be a power of two, so wrap explicitly
  assign w_grant_next = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= w_grant_next;
    end
  end

  // ---------------- return side ----------------

  // With no owner on record the result is accepted and dropped
  always_comb begin
    rsp_valid_o     = '0;
    dev_out_ready_o = 1'b0;
    if (!rst_i) begin
      if (w_fifo_empty) begin
        dev_out_ready_o = 1'b1;
      end else begin
        rsp_valid_o[w_head] = dev_out_valid_i & ~flush_i;
        dev_out_ready_o     = rsp_ready_i[w_head] & ~flush_i;
      end
    end
  end

  assign w_pop = ~w_fifo_empty & dev_out_valid_i & dev_out_ready_o;

  assign rsp_result_o = dev_result_i;
  assign rsp_status_o = dev_status_i;
  assign dev_flush_o  = flush_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_error <= 1'b0;
    end else if (w_fifo_empty && dev_out_valid_i) begin
      r_error <= 1'b1;
    end
  end

  assign error_o = r_error;
  assign busy_o  = (outstanding_o != '0);

  // ---------------- owner tracking ----------------

  complex_div_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (w_issue),
    .data_i  (w_grant_idx),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (outstanding_o)
  );

endmodule

// File: doc/complex_div_arbiter.md
Name: complex_div_arbiter

Overview:
Shares one complex_div instance between NUM_REQ requesters, such as lanes or cores issuing complex divides.
- Issue side: round-robin arbitration on the requester side.
- Tracking: an in-order ID FIFO records the issuing requester, because the divider carries no tag.
- Return side: each divider result is routed back to the requester that issued it.
- Position: sits between the requester ports and the complex_div handshake interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_OUTSTANDING, 4, ID FIFO depth = maximum operations in flight in complex_div (power of two, >=2).
- IDX_W, $clog2(NUM_REQ), requester index width (derived, not overridable).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  abort all in-flight operations.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester request accept.
- req_operands_i  in  NUM_REQ x 4 x 64  per-requester {b2,a2,b1,a1}, FP64.
- rsp_valid_o  out  NUM_REQ  per-requester result valid.
- rsp_ready_i  in  NUM_REQ  per-requester result accept.
- rsp_result_o  out  2 x 64  shared result bus {imag,real}; meaningful only where rsp_valid_o is set.
- rsp_status_o  out  5  shared fpnew_pkg::status_t.
- dev_operands_o  out  4 x 64  to complex_div operands_i.
- dev_valid_o  out  1  to complex_div in_valid_i.
- dev_ready_i  in  1  from complex_div in_ready_o.
- dev_result_i  in  2 x 64  from complex_div result_o.
- dev_status_i  in  5  from complex_div status_o.
- dev_out_valid_i  in  1  from complex_div out_valid_o.
- dev_out_ready_o  out  1  to complex_div out_ready_i.
- dev_flush_o  out  1  to complex_div flush_i.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  operations in flight.
- busy_o  out  1  outstanding_o != 0.
- error_o  out  1  sticky: result arrived with no ID in FIFO.

Behaviour:
- Reset (rst_i=1 at a clock edge): rr_ptr=0, FIFO empty, outstanding_o=0, error_o=0. While reset is asserted, all valid/ready outputs and dev_flush_o are 0. Reset mid-operation discards all IDs; results still arriving from the device are handled by the empty-FIFO rule below.
- can_issue = dev_ready_i & !fifo_full & !flush_i.
- Grant (combinational): the first requester with req_valid_i set, scanning from index rr_ptr upward with wrap to 0. The grant is qualified by can_issue.
- Issue outputs: dev_valid_o = any granted request; dev_operands_o = operands of the granted requester (0 when none). req_ready_o is one-hot at the granted index, else 0. Operands and grant are valid- and ptr-dependent only; they do not depend on req_ready_o.
- Issue handshake (dev_valid_o & dev_ready_i): push the granted index into the FIFO; rr_ptr <= (grant+1) mod NUM_REQ. Without a handshake rr_ptr holds.
- Full FIFO blocks issue even if a pop occurs in the same cycle. This is a decided simplification that avoids a combinational path from rsp_ready_i to dev_valid_o.
- Return: when the FIFO is not empty, head = FIFO head index.
  - rsp_valid_o[head] = dev_out_valid_i & !flush_i; all other rsp_valid_o bits are 0.
  - rsp_result_o/rsp_status_o pass dev_result_i/dev_status_i through.
  - dev_out_ready_o = rsp_ready_i[head] & !flush_i.
  - Pop on dev_out_valid_i & dev_out_ready_o.
- Empty-FIFO rule: when the FIFO is empty, rsp_valid_o=0 and dev_out_ready_o=1, so the result is dropped. If dev_out_valid_i=1 in that cycle, error_o <= 1 (sticky until rst_i).
- Outstanding count:
  - push & pop in the same cycle: count unchanged.
  - push only: +1.
  - pop only: -1.
  - Range 0..MAX_OUTSTANDING, never wraps.
- Flush (flush_i=1): dev_flush_o=1 in the same cycle; no grant, no pop. The FIFO empties and outstanding_o becomes 0 at the next edge; rr_ptr holds. Flush and reset asserted together: reset wins.
- Ordering: complex_div returns results in issue order, so the FIFO head is always the owner of the current result.
- Latency: arbiter adds 0 cycles on issue and 0 on return (pure combinational steering plus bookkeeping registers).

Decomposition:
- Package complex_div_arb_pkg: req_idx_t (logic [IDX_W-1:0]) and operand_t (logic [3:0][63:0]); status reused from fpnew_pkg::status_t.
- Sub-module complex_div_id_fifo: synchronous FIFO of req_idx_t.
  - Parameterised by DEPTH.
  - Ports: push, pop, clear, data in/out, full, empty, count.
  - The arbiter uses clear for flush.
- Round-robin grant logic stays inline.

Test Plan:
1. Single requester: req 2 issues a1=1.0,b1=0,a2=2.0,b2=0. Required: req_ready_o=4'b0100, FIFO holds {2}, rsp_valid_o=4'b0100 with real=0.5, imag=0.0, outstanding 1->0.
2. All 4 valid every cycle with dev_ready_i=1 and a device that holds results until MAX_OUTSTANDING ops are issued. Required: grants 0,1,2,3 in consecutive cycles, then the full FIFO blocks a 5th issue; results return to 0,1,2,3 in that order.
3. Backpressure: result for req 1 at FIFO head with rsp_ready_i[1]=0 for 3 cycles. Required: dev_out_ready_o=0 for 3 cycles, rsp_valid_o[1] held, pop on the 4th cycle only.
4. Flush with 3 in flight. Required: dev_flush_o=1 in the flush cycle, outstanding_o=0 and busy_o=0 next cycle, no rsp_valid_o; rr_ptr unchanged so the next grant follows the pre-flush order.
5. Spurious result: dev_out_valid_i=1 with an empty FIFO. Required: dev_out_ready_o=1, all rsp_valid_o=0, error_o=1 from the next cycle until rst_i.
6. Reset mid-operation: rst_i high for 1 cycle with 2 in flight. Required: all outputs 0, outstanding_o=0, next grant starts from index 0.
